// File: rtl/divider_32b_pkg.sv
// Shared constants, FSM encoding and two's-complement helpers for the 32-bit
// sequential restoring divider.
`ifndef DIVIDER_32B_PKG_SV
`define DIVIDER_32B_PKG_SV
package divider_32b_pkg;

  localparam int W     = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The single negate used by both operand magnitude and result sign fix-up.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic n);
    return n ? (~x + W'(1)) : x;
  endfunction

endpackage
`endif

// File: rtl/divider_32b_if.sv
// Request/result bundle for divider_32b; clock and reset stay outside.
interface divider_32b_if;
  logic        start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Q;
  logic [31:0] R;
  logic        busy;
  logic        done;
  logic        DZ;

  modport slave  (input  start, Signed, A, B,
                  output Q, R, busy, done, DZ);
  modport master (output start, Signed, A, B,
                  input  Q, R, busy, done, DZ);
endinterface

// File: rtl/divider_32b_sub_33b.sv
// 33-bit trial subtractor for one restoring-division step; borrow means the
// divisor did not fit.
module sub_33b (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  output logic [32:0] diff_o,
  output logic        borrow_o
);
  logic [33:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o   = full[32:0];
  assign borrow_o = full[33];
endmodule

// File: rtl/divider_32b.sv
// 32-bit signed/unsigned restoring divider: one quotient bit per cycle,
// sign fix-up in a separate state, divide-by-zero short-circuited to DONE.
module divider_32b
  import divider_32b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  divider_32b_if.slave bus
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     rem_q, dvd_q, dsr_q;
  logic             qneg_q, rneg_q;
  logic [W-1:0]     q_q, r_q;
  logic             busy_q, done_q, dz_q;

  logic [W:0]   trial, diff;
  logic         borrow;
  logic [W-1:0] rem_d, dvd_d;
  logic         a_neg, b_neg;
  logic         last_iter;
  logic         unused_diff_msb;

  // Remainder is always < divisor, so the shifted trial fits in 33 bits and
  // a successful difference fits back into 32.
  assign trial = {rem_q, dvd_q[W-1]};

  sub_33b u_sub (
    .a_i     (trial),
    .b_i     ({1'b0, dsr_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign unused_diff_msb = diff[W];
  assign rem_d     = borrow ? trial[W-1:0] : diff[W-1:0];
  assign dvd_d     = {dvd_q[W-2:0], ~borrow};
  assign a_neg     = bus.Signed & bus.A[W-1];
  assign b_neg     = bus.Signed & bus.B[W-1];
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dvd_q  <= cond_neg(bus.A, a_neg);
            dsr_q  <= cond_neg(bus.B, b_neg);
            rem_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            busy_q <= 1'b1;
            if (bus.B == '0) begin
              q_q     <= '1;
              r_q     <= bus.A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (last_iter) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIX: begin
          // Most-negative / -1 wraps naturally: magnitude 2^31 stays 2^31.
          q_q     <= cond_neg(dvd_q, qneg_q);
          r_q     <= cond_neg(rem_q, rneg_q);
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.DZ   = dz_q;

endmodule
